spislave: RTL and testbench

SPISLAVE -- requirements
Module: spislave

---
 rtl/spislave_pkg.sv | 10 +
 rtl/spislave_sync.sv | 31 +++
 rtl/spislave.sv | 85 ++++++++
 tb/tb_spislave.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/spislave_pkg.sv
// Shared constants and helpers for the SPI slave.
package spislave_pkg;
  localparam int DATA_W_DEFAULT = 8;
  localparam int SYNC_STAGES    = 2;

  // Bit counter width for a DATA_W-bit frame; never narrower than one bit.
  function automatic int cnt_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction
endpackage

// File: rtl/spislave_sync.sv
// Multi-flop synchronizer for one asynchronous input, plus rise/fall detection
// on the synchronized value.
module spislave_sync
  import spislave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;
endmodule

// File: rtl/spislave.sv
// SPI slave (sck idle low, MSB first, master samples on sck fall), fully
// clocked by clk; sck/ss/sdi are oversampled through synchronizers.
module spislave
  import spislave_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              sdi,
  output logic              sdo,
  input  logic              ss,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              ld,
  output logic              rdy
);
  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic w_sck_rise, w_sck_fall;
  logic w_ss_sync, w_ss_rise;
  logic w_sdi_sync;
  logic w_shift, w_last;
  logic [DATA_W-1:0] w_sr_next;

  logic [DATA_W-1:0] r_sr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sdo;
  logic              r_rdy_arm;
  logic              r_rdy;

  spislave_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .i_clk(clk), .i_rst(rst), .i_async(sck),
    .o_sync(), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spislave_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .i_clk(clk), .i_rst(rst), .i_async(ss),
    .o_sync(w_ss_sync), .o_rise(w_ss_rise), .o_fall()
  );

  spislave_sync #(.RST_VAL(1'b0)) u_sync_sdi (
    .i_clk(clk), .i_rst(rst), .i_async(sdi),
    .o_sync(w_sdi_sync), .o_rise(), .o_fall()
  );

  assign w_shift   = ~w_ss_sync & w_sck_fall;
  assign w_last    = w_shift & (r_cnt == LAST_BIT);
  assign w_sr_next = {r_sr[DATA_W-2:0], w_sdi_sync};

  // While selected, sck edges own sr; ld is only honoured between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr  <= '0;
      r_sdo <= 1'b0;
    end else if (!w_ss_sync) begin
      if (w_sck_fall) r_sr  <= w_sr_next;
      if (w_sck_rise) r_sdo <= r_sr[DATA_W-1];
    end else if (ld) begin
      r_sr <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_data    <= '0;
      r_rdy_arm <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_rdy_arm <= w_last;
      r_rdy     <= r_rdy_arm;
      if (w_ss_rise)    r_cnt <= '0;
      else if (w_shift) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last)       r_data <= w_sr_next;
    end
  end

  assign sdo    = w_ss_sync ? 1'b0 : r_sdo;
  assign data_o = r_data;
  assign rdy    = r_rdy;
endmodule

// File: tb/tb_spislave.sv
// Directed bench for spislave: an SPI master model drives frames and the
// received words, data_o, rdy pulses and reset behaviour are checked.
module tb_spislave;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sck = 1'b0;
  logic         sdi = 1'b0;
  logic         ss  = 1'b1;
  logic         ld  = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         sdo;
  logic [W-1:0] data_o;
  logic         rdy;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int rdy_cnt  = 0;
  int rdy_run  = 0;
  int rdy_max  = 0;
  int rdy_base = 0;
  logic [W-1:0] rx;
  logic         rb;

  spislave #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .sdo(sdo), .ss(ss),
    .data_i(data_i), .data_o(data_o), .ld(ld), .rdy(rdy)
  );

  always #5 clk = ~clk;

  // rdy monitor: counts high cycles and the longest consecutive run.
  always @(negedge clk) begin
    if (rdy) begin
      rdy_cnt++;
      rdy_run++;
      if (rdy_run > rdy_max) rdy_max = rdy_run;
    end else begin
      rdy_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit: master drives sdi after sck rises, samples sdo just before sck falls.
  task automatic spi_bit(input logic b, output logic r);
    sck = 1'b1;
    wait_clk(2);
    sdi = b;
    wait_clk(4);
    r = sdo;
    sck = 1'b0;
    wait_clk(6);
  endtask

  task automatic spi_frame(input logic [W-1:0] tx, input int nbits, output logic [W-1:0] rxo);
    logic r;
    rxo = '0;
    ss = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(tx[W-1-i], r);
      rxo = {rxo[W-2:0], r};
    end
    ss = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    // Reset state
    wait_clk(3);
    chk("rst_sdo", 32'(sdo), 32'h0);
    chk("rst_data_o", 32'(data_o), 32'h0);
    chk("rst_rdy", 32'(rdy), 32'h0);
    rst = 1'b0;
    wait_clk(4);

    // Load DE while deselected, then frame sending DE
    data_i = 8'hDE;
    ld = 1'b1;
    wait_clk(1);
    ld = 1'b0;
    chk("ld_sr", 32'(dut.r_sr), 32'hDE);
    rdy_base = rdy_cnt;
    spi_frame(8'hDE, W, rx);
    chk("f1_rx", 32'(rx), 32'hDE);
    chk("f1_data_o", 32'(data_o), 32'hDE);
    chk("f1_rdy", 32'(rdy_cnt - rdy_base), 32'd1);

    // Frame sending 00, no ld: echoes DE
    rdy_base = rdy_cnt;
    spi_frame(8'h00, W, rx);
    chk("f2_rx", 32'(rx), 32'hDE);
    chk("f2_data_o", 32'(data_o), 32'h00);
    chk("f2_rdy", 32'(rdy_cnt - rdy_base), 32'd1);

    // Frame sending DE, no ld: echoes 00
    rdy_base = rdy_cnt;
    spi_frame(8'hDE, W, rx);
    chk("f3_rx", 32'(rx), 32'h00);
    chk("f3_data_o", 32'(data_o), 32'hDE);
    chk("f3_rdy", 32'(rdy_cnt - rdy_base), 32'd1);

    // Partial frame of 5 bits (01010): no rdy, data_o held, sr = {DE[2:0],01010}
    rdy_base = rdy_cnt;
    spi_frame(8'h50, 5, rx);
    chk("part_rx", 32'(rx), 32'h1B);
    chk("part_data_o", 32'(data_o), 32'hDE);
    chk("part_rdy", 32'(rdy_cnt - rdy_base), 32'd0);
    chk("part_sr", 32'(dut.r_sr), 32'hCA);

    // Next full frame starts cleanly at bit 7
    rdy_base = rdy_cnt;
    spi_frame(8'h5A, W, rx);
    chk("f5_rx", 32'(rx), 32'hCA);
    chk("f5_data_o", 32'(data_o), 32'h5A);
    chk("f5_rdy", 32'(rdy_cnt - rdy_base), 32'd1);

    // ld while selected is ignored; frame transmits prior sr (5A)
    ss = 1'b0;
    wait_clk(4);
    data_i = 8'hA5;
    ld = 1'b1;
    wait_clk(1);
    ld = 1'b0;
    wait_clk(1);
    chk("ld_ss0_sr", 32'(dut.r_sr), 32'h5A);
    rdy_base = rdy_cnt;
    spi_frame(8'h33, W, rx);
    chk("f6_rx", 32'(rx), 32'h5A);
    chk("f6_data_o", 32'(data_o), 32'h33);
    chk("f6_rdy", 32'(rdy_cnt - rdy_base), 32'd1);

    // Reset in the middle of a frame; sr=33 so the third bit drives sdo=1
    ss = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, rb);
    chk("mid_sdo_pre", 32'(sdo), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sdo", 32'(sdo), 32'h0);
    chk("mid_rst_data_o", 32'(data_o), 32'h0);
    chk("mid_rst_rdy", 32'(rdy), 32'h0);
    chk("mid_rst_sr", 32'(dut.r_sr), 32'h0);
    wait_clk(3);
    rst = 1'b0;
    ss = 1'b1;
    wait_clk(8);

    // Frame after reset transmits zeros and receives 3C
    rdy_base = rdy_cnt;
    spi_frame(8'h3C, W, rx);
    chk("f7_rx", 32'(rx), 32'h00);
    chk("f7_data_o", 32'(data_o), 32'h3C);
    chk("f7_rdy", 32'(rdy_cnt - rdy_base), 32'd1);

    chk("rdy_width", 32'(rdy_max), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
